// File: rtl/register_file_pkg.sv
// Shared core types for TinyV: datapath width, register index width and the
// word/index typedefs used by the decoder, ALU, datapath and register file.
package register_file_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned REG_ADDR_WIDTH = 5;
   localparam int unsigned NUM_REGS       = 2 ** REG_ADDR_WIDTH;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
   typedef logic [DATA_WIDTH-1:0]     data_word_t;

   localparam reg_idx_t   REG_ZERO  = '0;
   localparam data_word_t WORD_ZERO = '0;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// TinyV integer register file: 2**REG_ADDR_WIDTH registers, two combinational
// read ports, one synchronous write port, x0 hardwired to zero, async
// active-high reset clearing all registers. No write-to-read bypass.
module register_file
   import register_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = register_file_pkg::DATA_WIDTH,
   parameter int unsigned REG_ADDR_WIDTH = register_file_pkg::REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      writeEnable,
   input  logic [REG_ADDR_WIDTH-1:0] addr_rs1,
   output logic [DATA_WIDTH-1:0]     rs1_data,
   input  logic [REG_ADDR_WIDTH-1:0] addr_rs2,
   output logic [DATA_WIDTH-1:0]     rs2_data,
   input  logic [REG_ADDR_WIDTH-1:0] addr_write,
   input  logic [DATA_WIDTH-1:0]     write_data
);

   localparam int unsigned REG_COUNT = 2 ** REG_ADDR_WIDTH;
   localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ZERO = '0;

   logic [DATA_WIDTH-1:0] regs [REG_COUNT];
   logic                  write_hit;

   // A write only lands when enabled and not aimed at x0.
   assign write_hit = writeEnable && (addr_write != ADDR_ZERO);

   // Storage: asynchronous clear on reset, single write port otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (write_hit) begin
         regs[addr_write] <= write_data;
      end
   end

   // Read port 1: x0 forced to zero; reset gates output in the same time step.
   always_comb begin
      rs1_data = '0;
      if (!reset && (addr_rs1 != ADDR_ZERO)) begin
         rs1_data = regs[addr_rs1];
      end
   end

   // Read port 2: same structure as port 1, fully independent.
   always_comb begin
      rs2_data = '0;
      if (!reset && (addr_rs2 != ADDR_ZERO)) begin
         rs2_data = regs[addr_rs2];
      end
   end

   // x0 always reads zero on both ports.
   a_x0_rs1 : assert property (@(posedge clk) disable iff (reset)
      (addr_rs1 == ADDR_ZERO) |-> (rs1_data == '0));
   a_x0_rs2 : assert property (@(posedge clk) disable iff (reset)
      (addr_rs2 == ADDR_ZERO) |-> (rs2_data == '0));

   // Outputs never carry X once out of reset.
   a_no_x_out : assert property (@(posedge clk) disable iff (reset)
      !$isunknown({rs1_data, rs2_data}));

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk;
   logic          reset;
   logic          writeEnable;
   logic [AW-1:0] addr_rs1;
   logic [DW-1:0] rs1_data;
   logic [AW-1:0] addr_rs2;
   logic [DW-1:0] rs2_data;
   logic [AW-1:0] addr_write;
   logic [DW-1:0] write_data;

   int checks = 0;
   int errors = 0;

   register_file dut (
      .clk         (clk),
      .reset       (reset),
      .writeEnable (writeEnable),
      .addr_rs1    (addr_rs1),
      .rs1_data    (rs1_data),
      .addr_rs2    (addr_rs2),
      .rs2_data    (rs2_data),
      .addr_write  (addr_write),
      .write_data  (write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Present a write before the rising edge, sample just after it.
   task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      writeEnable = 1'b1;
      addr_write  = a;
      write_data  = d;
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      writeEnable = 1'b0;
      addr_rs1    = 5'd5;
      addr_rs2    = 5'd31;
      addr_write  = '0;
      write_data  = '0;

      #12;
      check("rst_rs1", rs1_data, 32'h0);
      check("rst_rs2", rs2_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_x5", rs1_data, 32'h0);
      check("post_rst_x31", rs2_data, 32'h0);

      write_reg(5'd1, 32'hA5A5A5A5);
      addr_rs1 = 5'd1;
      #1 check("x1_rs1", rs1_data, 32'hA5A5A5A5);

      write_reg(5'd2, 32'h5A5A5A5A);
      addr_rs2 = 5'd2;
      #1 check("x2_rs2", rs2_data, 32'h5A5A5A5A);

      write_reg(5'd0, 32'hDEADBEEF);
      addr_rs1 = 5'd0;
      #1 check("x0_rs1", rs1_data, 32'h0);

      // Read of the register being written: old value before the edge, new after.
      @(negedge clk);
      addr_rs1    = 5'd6;
      addr_write  = 5'd6;
      write_data  = 32'hCAFEBABE;
      writeEnable = 1'b1;
      #1 check("x6_pre_edge", rs1_data, 32'h0);
      @(posedge clk);
      #1 check("x6_post_edge", rs1_data, 32'hCAFEBABE);
      writeEnable = 1'b0;

      write_reg(5'd31, 32'hFFFFFFFF);
      addr_rs2 = 5'd31;
      #1 check("x31_rs2", rs2_data, 32'hFFFFFFFF);

      // Enable low: address and data toggle, storage must not move.
      @(negedge clk);
      writeEnable = 1'b0;
      addr_write  = 5'd31;
      write_data  = 32'h12345678;
      @(posedge clk);
      #1 check("x31_we0", rs2_data, 32'hFFFFFFFF);

      // Same register on both ports, then different registers.
      addr_rs1 = 5'd1;
      addr_rs2 = 5'd1;
      #1;
      check("same_rs1", rs1_data, 32'hA5A5A5A5);
      check("same_rs2", rs2_data, 32'hA5A5A5A5);
      addr_rs1 = 5'd2;
      addr_rs2 = 5'd6;
      #1;
      check("diff_rs1", rs1_data, 32'h5A5A5A5A);
      check("diff_rs2", rs2_data, 32'hCAFEBABE);

      write_reg(5'd3, 32'h11223344);
      addr_rs1 = 5'd3;
      #1 check("x3_rs1", rs1_data, 32'h11223344);

      // Mid-cycle reset with a write pending to x4: reset wins.
      @(negedge clk);
      writeEnable = 1'b1;
      addr_write  = 5'd4;
      write_data  = 32'h0BADF00D;
      #2 reset = 1'b1;
      addr_rs2 = 5'd31;
      #1;
      check("rst_mid_x3", rs1_data, 32'h0);
      check("rst_mid_x31", rs2_data, 32'h0);
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      addr_rs2 = 5'd4;
      #1;
      check("after_rst_x3", rs1_data, 32'h0);
      check("after_rst_x4", rs2_data, 32'h0);

      write_reg(5'd3, 32'h89ABCDEF);
      #1 check("x3_rewrite", rs1_data, 32'h89ABCDEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_register_file
